// File: rtl/i2c_multi_filter_pkg.sv
// Shared I2C line-filter defaults and legal parameter ranges.
// Defaults give the usual 2-line (SDA, SCL) filter with a 2-flop synchroniser.
package i2c_multi_filter_pkg;

  localparam int I2C_NUM_CH_DEF  = 2;
  localparam int I2C_NUM_CH_MIN  = 1;
  localparam int I2C_NUM_CH_MAX  = 16;

  localparam int I2C_SYNC_DEF    = 2;
  localparam int I2C_SYNC_MIN    = 1;
  localparam int I2C_SYNC_MAX    = 4;

  localparam int I2C_FLEN_DEF    = 3;
  localparam int I2C_FLEN_MIN    = 1;
  localparam int I2C_FLEN_MAX    = 255;

endpackage

// File: rtl/i2c_filter_chan.sv
// One line: synchroniser, run-length glitch filter, registered edge/glitch strobes.
// Latency SYNC_STAGES+FILTER_LEN edges; no backpressure (free-running sampler).
module i2c_filter_chan #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3,
  parameter bit RESET_VAL   = 1'b1
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic raw_i,
  input  logic bypass_i,
  output logic filt_o,
  output logic rise_o,
  output logic fall_o,
  output logic glitch_o
);

  function automatic int cnt_width(input int len);
    int w = 1;
    while ((1 << w) < len + 1) w++;
    return w;
  endfunction

  localparam int             CW       = cnt_width(FILTER_LEN);
  localparam logic [CW-1:0]  CNT_LAST = CW'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          cnt_d;
  logic                   filt_d;
  logic                   glitch_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  // A rejected run is reported when the line returns to the filtered level
  // while differing samples were still being counted.
  always_comb begin
    cnt_d    = '0;
    filt_d   = filt_o;
    glitch_d = 1'b0;
    if (bypass_i) begin
      filt_d = s;
    end else if (s == filt_o) begin
      glitch_d = (cnt_q != '0);
    end else if (cnt_q == CNT_LAST) begin
      filt_d = s;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q   <= {SYNC_STAGES{RESET_VAL}};
      cnt_q    <= '0;
      filt_o   <= RESET_VAL;
      rise_o   <= 1'b0;
      fall_o   <= 1'b0;
      glitch_o <= 1'b0;
    end else begin
      sync_q[0] <= raw_i;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
      cnt_q    <= cnt_d;
      filt_o   <= filt_d;
      rise_o   <= filt_d & ~filt_o;
      fall_o   <= ~filt_d & filt_o;
      glitch_o <= glitch_d;
    end
  end

endmodule

// File: rtl/i2c_multi_filter.sv
// NUM_CH independent I2C line filters (ch0 = SDA, ch1 = SCL) sharing one bypass.
// Latency SYNC_STAGES+FILTER_LEN edges per line; no backpressure.
module i2c_multi_filter
  import i2c_multi_filter_pkg::*;
#(
  parameter int                NUM_CH      = I2C_NUM_CH_DEF,
  parameter int                SYNC_STAGES = I2C_SYNC_DEF,
  parameter int                FILTER_LEN  = I2C_FLEN_DEF,
  parameter logic [NUM_CH-1:0] RESET_VAL   = '1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [NUM_CH-1:0] raw_i,
  input  logic              bypass_i,
  output logic [NUM_CH-1:0] filt_o,
  output logic [NUM_CH-1:0] rise_o,
  output logic [NUM_CH-1:0] fall_o,
  output logic [NUM_CH-1:0] glitch_o
);

  if (NUM_CH < I2C_NUM_CH_MIN || NUM_CH > I2C_NUM_CH_MAX) begin : g_bad_num_ch
    $error("i2c_multi_filter: NUM_CH out of range 1..16");
  end
  if (SYNC_STAGES < I2C_SYNC_MIN || SYNC_STAGES > I2C_SYNC_MAX) begin : g_bad_sync
    $error("i2c_multi_filter: SYNC_STAGES out of range 1..4");
  end
  if (FILTER_LEN < I2C_FLEN_MIN || FILTER_LEN > I2C_FLEN_MAX) begin : g_bad_flen
    $error("i2c_multi_filter: FILTER_LEN out of range 1..255");
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    i2c_filter_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN),
      .RESET_VAL   (RESET_VAL[i])
    ) u_chan (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .raw_i    (raw_i[i]),
      .bypass_i (bypass_i),
      .filt_o   (filt_o[i]),
      .rise_o   (rise_o[i]),
      .fall_o   (fall_o[i]),
      .glitch_o (glitch_o[i])
    );
  end

endmodule

// File: tb/tb_i2c_multi_filter.sv
// Randomised and directed bench for i2c_multi_filter against a sample-history model.
// A second instance covers FILTER_LEN = 1 with four channels.
module tb_i2c_multi_filter;

  localparam int NCH  = 2;
  localparam int SS   = 2;
  localparam int FL   = 3;
  localparam int MAXC = 8192;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             bypass;
  logic [NCH-1:0]   raw;
  logic [NCH-1:0]   filt, rise, fall, glitch;
  logic             bypass4;
  logic [3:0]       raw4, filt4, rise4, fall4, glitch4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  i2c_multi_filter dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .raw_i    (raw),
    .bypass_i (bypass),
    .filt_o   (filt),
    .rise_o   (rise),
    .fall_o   (fall),
    .glitch_o (glitch)
  );

  i2c_multi_filter #(.NUM_CH(4), .FILTER_LEN(1)) dut4 (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .raw_i    (raw4),
    .bypass_i (bypass4),
    .filt_o   (filt4),
    .rise_o   (rise4),
    .fall_o   (fall4),
    .glitch_o (glitch4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: a level change is accepted once FL consecutive samples, all taken
  // since the last accepted change / reset / bypass, differ from the output.
  int           n;
  bit           rawh  [NCH][MAXC];
  bit           shist [NCH][MAXC];
  int           restart [NCH];
  bit [NCH-1:0] fm, rm, fam, gm;

  task automatic model_reset();
    n = 0;
    fm = '1; rm = '0; fam = '0; gm = '0;
    for (int c = 0; c < NCH; c++) restart[c] = 1;
  endtask

  task automatic model_step();
    n++;
    for (int c = 0; c < NCH; c++) begin
      bit s, old, flip;
      rawh[c][n] = raw[c];
      s = (n > SS) ? rawh[c][n-SS] : 1'b1;
      shist[c][n] = s;
      old = fm[c];
      gm[c] = 1'b0;
      if (bypass) begin
        fm[c] = s;
        restart[c] = n + 1;
      end else begin
        flip = (n - FL + 1 >= restart[c]);
        if (flip)
          for (int k = n - FL + 1; k <= n; k++)
            if (shist[c][k] == old) flip = 1'b0;
        if (flip) begin
          fm[c] = ~old;
          restart[c] = n + 1;
        end else if (s == old && n - 1 >= restart[c] && shist[c][n-1] != old) begin
          gm[c] = 1'b1;
        end
      end
      rm[c]  = fm[c] & ~old;
      fam[c] = ~fm[c] & old;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk($sformatf("filt@%0d", n), filt, fm);
    chk($sformatf("rise@%0d", n), rise, rm);
    chk($sformatf("fall@%0d", n), fall, fam);
    chk($sformatf("glitch@%0d", n), glitch, gm);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst filt", filt, 2'b11);
    chk("rst strobes", {rise, fall, glitch}, 6'b0);
    chk("rst filt4", filt4, 4'hF);
    chk("rst strobes4", {rise4, fall4, glitch4}, 12'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int first, cnt_a, cnt_b, cnt_c, edge_a, edge_b;
    int hold [NCH];
    int bl;
    rst_n   = 1'b1;
    raw     = 2'b11;
    bypass  = 1'b0;
    raw4    = 4'hF;
    bypass4 = 1'b0;
    #2;
    do_reset();

    // Idle-high lines stay high with no strobes
    cnt_a = 0;
    for (int e = 1; e <= 20; e++) begin
      cycle();
      if (filt != 2'b11 || (rise | fall | glitch) != 0) cnt_a++;
    end
    chk("idle cycles disturbed", cnt_a, 0);

    // SDA falls and stays low
    raw = 2'b10;
    first = -1; cnt_a = 0; edge_a = -1; cnt_b = 0;
    for (int e = 1; e <= 8; e++) begin
      cycle();
      if (first < 0 && filt[0] == 1'b0) first = e;
      if (fall[0]) begin cnt_a++; edge_a = e; end
      if (filt[1] != 1'b1 || rise[1] || fall[1] || glitch[1]) cnt_b++;
    end
    chk("sda fall latency", first, 5);
    chk("sda fall strobe edge", edge_a, 5);
    chk("sda fall strobe count", cnt_a, 1);
    chk("scl disturbed", cnt_b, 0);

    raw = 2'b11;
    repeat (8) cycle();

    // Two-sample SCL low pulse is rejected
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    for (int e = 1; e <= 10; e++) begin
      raw = (e <= 2) ? 2'b01 : 2'b11;
      cycle();
      cnt_a += glitch[1];
      cnt_b += fall[1];
      if (filt[1] == 1'b0) cnt_c++;
    end
    chk("scl glitch count", cnt_a, 1);
    chk("scl fall count", cnt_b, 0);
    chk("scl low cycles", cnt_c, 0);

    // Bypass: one-cycle SDA pulse passes straight through
    bypass = 1'b1;
    repeat (3) cycle();
    cnt_a = 0; cnt_b = 0; cnt_c = 0; edge_a = -1; edge_b = -1;
    for (int e = 1; e <= 8; e++) begin
      raw = (e == 1) ? 2'b10 : 2'b11;
      cycle();
      if (filt[0] == 1'b0) cnt_a++;
      if (fall[0]) edge_a = e;
      if (rise[0]) edge_b = e;
      cnt_b += glitch[0] + glitch[1];
    end
    chk("byp low cycles", cnt_a, 1);
    chk("byp fall edge", edge_a, 3);
    chk("byp rise edge", edge_b, 4);
    chk("byp glitches", cnt_b, 0);
    bypass = 1'b0;
    repeat (4) cycle();

    // Reset lands on a pending change on both lines
    raw = 2'b10;
    repeat (8) cycle();
    raw = 2'b01;
    repeat (4) cycle();
    do_reset();
    first = -1; cnt_a = 0; edge_a = -1; cnt_b = 0;
    for (int e = 1; e <= 8; e++) begin
      cycle();
      if (first < 0 && filt[1] == 1'b0) first = e;
      if (fall[1]) begin cnt_a++; edge_a = e; end
      if (e < 5 && (rise | fall | glitch) != 0) cnt_b++;
      if (filt[0] != 1'b1 || rise[0] || fall[0] || glitch[0]) cnt_b++;
    end
    chk("post-rst scl latency", first, 5);
    chk("post-rst scl fall count", cnt_a, 1);
    chk("post-rst spurious", cnt_b, 0);

    // Random runs on both lines with occasional bypass and one reset
    for (int c = 0; c < NCH; c++) hold[c] = 0;
    bl = 0;
    for (int i = 0; i < 2000; i++) begin
      for (int c = 0; c < NCH; c++) begin
        if (hold[c] == 0) begin
          raw[c]  = ~raw[c];
          hold[c] = $urandom_range(1, 7);
        end
        hold[c]--;
      end
      if (bl > 0) bl--;
      else if ($urandom_range(0, 59) == 0) bl = $urandom_range(1, 5);
      bypass = (bl > 0);
      if (i == 1000) do_reset();
      cycle();
    end
    bypass = 1'b0;
    raw = 2'b11;
    repeat (8) cycle();

    // FILTER_LEN = 1, four lines fall together
    raw4 = 4'h0;
    first = -1; cnt_a = 0; edge_a = -1; cnt_b = 0;
    for (int e = 1; e <= 6; e++) begin
      cycle();
      if (first < 0 && filt4 == 4'h0) first = e;
      if (fall4 != 4'h0) begin cnt_a++; edge_a = e; end
      if (fall4 != 4'h0 && fall4 != 4'hF) cnt_b++;
      if (glitch4 != 4'h0 || rise4 != 4'h0) cnt_b++;
    end
    chk("len1 latency", first, 3);
    chk("len1 fall edge", edge_a, 3);
    chk("len1 fall cycles", cnt_a, 1);
    chk("len1 bad strobes", cnt_b, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
